ov7670_sccb_config: RTL and testbench

- Sequences the OV7670 power-up register configuration over SCCB (3-phase write: device address, register address, data).
- Walks a constant table of {reg, data} entries from the sub-module ov7670_config_rom.
- Drives sioc/siod to the sensor, with siod tri-state control resolved at top level.
- Runs on the system clock, ahead of the pclk-domain capture controller. Signals done when the sensor is streaming RGB565.

---
 rtl/ov7670_pkg.sv | 31 +++
 rtl/ov7670_config_rom.sv | 34 +++
 rtl/ov7670_sccb_config.sv | 212 +++++++++++++++++++++
 tb/tb_ov7670_sccb_config.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared constants, state type and frame helpers for the OV7670 SCCB sequencer
package ov7670_pkg;

    localparam logic [7:0]  SCCB_WR_ADDR = 8'h42;
    localparam logic [15:0] CFG_END      = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY    = 16'hFFF0;
    localparam logic [4:0]  LAST_BIT     = 5'd26;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        BITS,
        STOP,
        GAP,
        DELAY,
        DONE
    } sccb_state_t;

    // Bits 8, 17 and 26 are the slave's don't-care/ACK slots.
    function automatic logic is_ack_bit(input logic [4:0] b);
        return (b == 5'd8) || (b == 5'd17) || (b == LAST_BIT);
    endfunction

    function automatic logic frame_bit(input logic [26:0] frame, input logic [4:0] b);
        logic [26:0] sh;
        sh = frame << b;
        return sh[26];
    endfunction

endpackage

// File: rtl/ov7670_config_rom.sv
// rtl/ov7670_config_rom.sv - constant {reg, data} bring-up table; ROM_SEL picks an alternate table
module ov7670_config_rom
    import ov7670_pkg::*;
#(
    parameter int ROM_SEL = 0
) (
    input  logic [7:0]  idx,
    output logic [15:0] rom_data
);

    // ROM_SEL: 0 = full sensor bring-up, 1 = single COM7 write, 2 = empty table.
    always_comb begin
        rom_data = CFG_END;
        if (ROM_SEL == 1) begin
            if (idx == 8'd0) begin
                rom_data = 16'h1204;
            end
        end else if (ROM_SEL == 0) begin
            case (idx)
                8'd0:    rom_data = 16'h1280;
                8'd1:    rom_data = CFG_DELAY;
                8'd2:    rom_data = 16'h1204;
                8'd3:    rom_data = 16'h40D0;
                8'd4:    rom_data = 16'h8C00;
                8'd5:    rom_data = 16'h1180;
                8'd6:    rom_data = 16'h3A04;
                8'd7:    rom_data = 16'h1500;
                8'd8:    rom_data = 16'h3DC0;
                default: rom_data = CFG_END;
            endcase
        end
    end

endmodule

// File: rtl/ov7670_sccb_config.sv
// rtl/ov7670_sccb_config.sv - walks the config ROM and issues each entry as a 3-phase SCCB write
module ov7670_sccb_config
    import ov7670_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int SCCB_FREQ_HZ = 100_000,
    parameter int DELAY_CYCLES = 1_000_000,
    parameter int ROM_SEL      = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       sioc,
    output logic       siod_out,
    output logic       siod_oe,
    output logic       busy,
    output logic       done,
    output logic [7:0] entry_idx
);

    localparam int QDIV = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int DW   = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);
    localparam logic [DW-1:0] DLAST = DW'(DELAY_CYCLES - 1);

    sccb_state_t   state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    quarter_q, quarter_d;
    logic [4:0]    bit_q, bit_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [15:0]   entry_q, entry_d;
    logic [7:0]    idx_q, idx_d;
    logic          sioc_q, sioc_d;
    logic          siod_q, siod_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [15:0] rom_data;
    logic [26:0] frame;
    logic        qtick;
    logic [4:0]  nb;

    ov7670_config_rom #(.ROM_SEL(ROM_SEL)) u_rom (
        .idx      (idx_q),
        .rom_data (rom_data)
    );

    assign frame = {SCCB_WR_ADDR, 1'b1, entry_q[15:8], 1'b1, entry_q[7:0], 1'b1};

    always_comb begin
        state_d   = state_q;
        qcnt_d    = '0;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        dcnt_d    = dcnt_q;
        entry_d   = entry_q;
        idx_d     = idx_q;
        sioc_d    = sioc_q;
        siod_d    = siod_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        done_d    = done_q;
        qtick     = 1'b0;
        nb        = (state_q == START) ? 5'd0 : bit_q + 5'd1;

        // FETCH holds the divider at zero so every START begins on a fresh quarter.
        if (state_q inside {START, BITS, STOP, GAP, DELAY}) begin
            qtick  = (qcnt_q == QLAST);
            qcnt_d = qtick ? '0 : qcnt_q + 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = FETCH;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            FETCH: begin
                entry_d = rom_data;
                if (rom_data == CFG_END) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (rom_data == CFG_DELAY) begin
                    state_d = DELAY;
                    dcnt_d  = '0;
                end else begin
                    state_d   = START;
                    quarter_d = 2'd0;
                    sioc_d    = 1'b1;
                    siod_d    = 1'b1;
                    oe_d      = 1'b1;
                end
            end
            START: begin
                if (qtick) begin
                    case (quarter_q)
                        2'd0: begin
                            quarter_d = 2'd1;
                            siod_d    = 1'b0;
                        end
                        2'd1: begin
                            quarter_d = 2'd2;
                            sioc_d    = 1'b0;
                        end
                        default: begin
                            state_d   = BITS;
                            quarter_d = 2'd0;
                            bit_d     = nb;
                            sioc_d    = 1'b0;
                            siod_d    = frame_bit(frame, nb);
                            oe_d      = !is_ack_bit(nb);
                        end
                    endcase
                end
            end
            BITS: begin
                if (qtick) begin
                    quarter_d = quarter_q + 2'd1;
                    if (quarter_q == 2'd1) begin
                        sioc_d = 1'b1;
                    end else if (quarter_q == 2'd3) begin
                        sioc_d = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            state_d = STOP;
                            siod_d  = 1'b0;
                            oe_d    = 1'b1;
                        end else begin
                            bit_d  = nb;
                            siod_d = frame_bit(frame, nb);
                            oe_d   = !is_ack_bit(nb);
                        end
                    end
                end
            end
            STOP: begin
                if (qtick) begin
                    quarter_d = quarter_q + 2'd1;
                    if (quarter_q == 2'd0) begin
                        sioc_d = 1'b1;
                    end else if (quarter_q == 2'd1) begin
                        siod_d = 1'b1;
                    end else begin
                        state_d   = GAP;
                        quarter_d = 2'd0;
                    end
                end
            end
            GAP: begin
                if (qtick) begin
                    quarter_d = quarter_q + 2'd1;
                    if (quarter_q == 2'd3) begin
                        state_d = FETCH;
                        idx_d   = idx_q + 8'd1;
                    end
                end
            end
            DELAY: begin
                if (dcnt_q == DLAST) begin
                    state_d = FETCH;
                    idx_d   = idx_q + 8'd1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            qcnt_q    <= '0;
            quarter_q <= 2'd0;
            bit_q     <= 5'd0;
            dcnt_q    <= '0;
            entry_q   <= 16'h0000;
            idx_q     <= 8'd0;
            sioc_q    <= 1'b1;
            siod_q    <= 1'b1;
            oe_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            dcnt_q    <= dcnt_d;
            entry_q   <= entry_d;
            idx_q     <= idx_d;
            sioc_q    <= sioc_d;
            siod_q    <= siod_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign sioc      = sioc_q;
    assign siod_out  = siod_q;
    assign siod_oe   = oe_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign entry_idx = idx_q;

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// tb/tb_ov7670_sccb_config.sv - scoreboard bench: default, single-entry and empty ROM instances
module tb_ov7670_sccb_config;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start = 3'b000;

    wire [2:0] sioc_w, siod_w, oe_w, busy_w, done_w;
    wire [7:0] idx_w [3];

    int n_cmp = 0;
    int n_bad = 0;

    byte         exp_ev  [3][$];
    int          exp_idx [3][$];
    logic [15:0] dflt_rom [10];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ov7670_sccb_config #(
            .CLK_FREQ_HZ  (4000),
            .SCCB_FREQ_HZ (100),
            .DELAY_CYCLES (50),
            .ROM_SEL      (g)
        ) u_dut (
            .clk       (clk),
            .reset     (rst),
            .start     (start[g]),
            .sioc      (sioc_w[g]),
            .siod_out  (siod_w[g]),
            .siod_oe   (oe_w[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g]),
            .entry_idx (idx_w[g])
        );
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_ev(input int g, input byte got);
        byte want;
        n_cmp++;
        if (exp_ev[g].size() == 0) begin
            n_bad++;
            $display("FAIL bus_event dut%0d: got '%c', required no activity", g, got);
        end else begin
            want = exp_ev[g].pop_front();
            if (got != want) begin
                n_bad++;
                $display("FAIL bus_event dut%0d: got '%c', required '%c'", g, got, want);
            end
        end
    endtask

    task automatic check_idx(input int g, input int got);
        int want;
        n_cmp++;
        if (exp_idx[g].size() == 0) begin
            n_bad++;
            $display("FAIL entry_idx dut%0d: got %0d, required no change", g, got);
        end else begin
            want = exp_idx[g].pop_front();
            if (got != want) begin
                n_bad++;
                $display("FAIL entry_idx dut%0d: got %0d, required %0d", g, got, want);
            end
        end
    endtask

    // Bus monitor: a rising sioc is a data bit ('X' when released), siod moving
    // while sioc is high is a start ('S') or stop ('P') condition.
    for (genvar g = 0; g < 3; g++) begin : g_mon
        logic       p_sioc = 1'b1;
        logic       p_siod = 1'b1;
        logic       p_oe   = 1'b1;
        logic [7:0] p_idx  = 8'd0;
        byte        ev;
        always @(negedge clk) begin
            ev = 8'd0;
            if (!rst) begin
                if (!p_sioc && sioc_w[g]) begin
                    ev = oe_w[g] ? (siod_w[g] ? "1" : "0") : "X";
                end else if (p_sioc && sioc_w[g] && p_oe && oe_w[g] && (p_siod != siod_w[g])) begin
                    ev = siod_w[g] ? "P" : "S";
                end
                if (ev != 8'd0) check_ev(g, ev);
                if (idx_w[g] != p_idx) check_idx(g, int'(idx_w[g]));
            end
            p_sioc = sioc_w[g];
            p_siod = siod_w[g];
            p_oe   = oe_w[g];
            p_idx  = idx_w[g];
        end
    end

    task automatic push_str(input int g, input string s);
        for (int i = 0; i < s.len(); i++) exp_ev[g].push_back(s[i]);
    endtask

    task automatic push_txn(input int g, input logic [15:0] e);
        logic [7:0] b [3];
        b[0] = 8'h42;
        b[1] = e[15:8];
        b[2] = e[7:0];
        exp_ev[g].push_back("S");
        for (int p = 0; p < 3; p++) begin
            for (int i = 7; i >= 0; i--) exp_ev[g].push_back(b[p][i] ? "1" : "0");
            exp_ev[g].push_back("X");
        end
        exp_ev[g].push_back("0");
        exp_ev[g].push_back("P");
    endtask

    task automatic push_run(input int g, input bit idx_was_nonzero);
        if (idx_was_nonzero) exp_idx[g].push_back(0);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) exp_idx[g].push_back(k);
            if (dflt_rom[k] == 16'hFFFF) break;
            if (dflt_rom[k] != 16'hFFF0) push_txn(g, dflt_rom[k]);
        end
    endtask

    task automatic pulse_start(input int g);
        @(negedge clk);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int limit, output int n);
        n = 0;
        while (!done_w[g] && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n1;
        int bad1;
        int idle_bad;

        dflt_rom = '{16'h1280, 16'hFFF0, 16'h1204, 16'h40D0, 16'h8C00,
                     16'h1180, 16'h3A04, 16'h1500, 16'h3DC0, 16'hFFFF};

        repeat (3) @(negedge clk);
        check("rst_sioc", sioc_w[0], 1);
        check("rst_siod", siod_w[0], 1);
        check("rst_oe", oe_w[0], 1);
        check("rst_busy", busy_w[0], 0);
        check("rst_done", done_w[0], 0);
        check("rst_idx", idx_w[0], 0);
        rst = 1'b0;

        idle_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if ({sioc_w[0], siod_w[0], oe_w[0], busy_w[0], done_w[0]} != 5'b11100) idle_bad++;
        end
        check("idle_lines", idle_bad, 0);

        // Single COM7 write: hand-expanded 42 / 12 / 04 frame.
        push_str(1, "S01000010X00010010X00000100X0P");
        exp_idx[1].push_back(1);
        pulse_start(1);
        check("one_busy_after_start", busy_w[1], 1);
        check("one_done_after_start", done_w[1], 0);
        wait_done(1, 5000, n);
        check("one_done_latency", n, 118 * 10 + 2);
        check("one_busy_at_done", busy_w[1], 0);
        check("one_ev_left", exp_ev[1].size(), 0);

        // Full table; a start issued at entry 3 must be ignored.
        push_run(0, 1'b0);
        pulse_start(0);
        n = 0;
        n1 = 0;
        bad1 = 0;
        while (idx_w[0] != 8'd3 && n < 20000) begin
            @(negedge clk);
            n++;
            if (idx_w[0] == 8'd1) begin
                n1++;
                if (!sioc_w[0] || !siod_w[0] || !oe_w[0]) bad1++;
            end
        end
        check("reach_entry3", idx_w[0], 3);
        check("delay_entry_clks", n1, 51);
        check("delay_idle_lines", bad1, 0);
        pulse_start(0);
        wait_done(0, 20000, n);
        check("dflt_done", done_w[0], 1);
        check("dflt_busy", busy_w[0], 0);
        check("dflt_last_idx", idx_w[0], 9);
        check("dflt_ev_left", exp_ev[0].size(), 0);
        check("dflt_idx_left", exp_idx[0].size(), 0);

        // Rerun from entry 0, then reset inside bit 12 of the first write.
        push_run(0, 1'b1);
        pulse_start(0);
        check("rerun_done_cleared", done_w[0], 0);
        check("rerun_busy", busy_w[0], 1);
        check("rerun_idx", idx_w[0], 0);
        repeat (516) @(negedge clk);
        check("pre_reset_sioc", sioc_w[0], 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_sioc", sioc_w[0], 1);
        check("mid_rst_siod", siod_w[0], 1);
        check("mid_rst_oe", oe_w[0], 1);
        check("mid_rst_busy", busy_w[0], 0);
        exp_ev[0].delete();
        exp_idx[0].delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_run(0, 1'b0);
        pulse_start(0);
        wait_done(0, 20000, n);
        check("post_rst_done", done_w[0], 1);
        check("post_rst_last_idx", idx_w[0], 9);
        check("post_rst_ev_left", exp_ev[0].size(), 0);

        // Empty table: one busy cycle, then done, and the bus never moves.
        pulse_start(2);
        check("empty_busy", busy_w[2], 1);
        check("empty_done_early", done_w[2], 0);
        @(negedge clk);
        check("empty_busy_off", busy_w[2], 0);
        check("empty_done", done_w[2], 1);
        repeat (20) @(negedge clk);
        check("empty_sioc", sioc_w[2], 1);

        for (int g = 0; g < 3; g++) begin
            check($sformatf("final_ev_left%0d", g), exp_ev[g].size(), 0);
            check($sformatf("final_idx_left%0d", g), exp_idx[g].size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
